// File: rtl/gpu_pkg.sv
// Shared GPU front-end definitions: thread-ID sizing and the dispatch FSM state encoding.
package gpu_pkg;
  localparam int ID_W        = 3;
  localparam int MAX_THREADS = 2**ID_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DONE     = 2'd2
  } dispatch_state_e;
endpackage

// File: rtl/thread_dispatch.sv
// Issues thread IDs 0..N-1 for one launch over a valid/ready port; first ID one cycle after start,
// then one ID per cycle while tid_ready=1, ID held stable while stalled; all outputs registered.
module thread_dispatch #(
  parameter int ID_W        = gpu_pkg::ID_W,
  parameter int MAX_THREADS = 2**ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ID_W:0]   thread_count,
  output logic            busy,
  output logic            tid_valid,
  input  logic            tid_ready,
  output logic [ID_W-1:0] tid,
  output logic            tid_last,
  output logic            done
);
  import gpu_pkg::*;

  localparam logic [ID_W:0] MAX_CNT = (ID_W+1)'(MAX_THREADS);

  dispatch_state_e state_q;
  logic [ID_W:0]   cnt_q;
  logic [ID_W:0]   id_q;
  logic            tid_valid_q;
  logic            tid_last_q;
  logic            busy_q;
  logic            done_q;
  logic [ID_W:0]   clamped_d;

  assign clamped_d = (thread_count > MAX_CNT) ? MAX_CNT : thread_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      id_q        <= '0;
      tid_valid_q <= 1'b0;
      tid_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (thread_count == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_DISPATCH;
              cnt_q       <= clamped_d;
              id_q        <= '0;
              tid_valid_q <= 1'b1;
              tid_last_q  <= (clamped_d == (ID_W+1)'(1));
              busy_q      <= 1'b1;
            end
          end
        end
        ST_DISPATCH: begin
          if (tid_ready) begin
            if (tid_last_q) begin
              state_q     <= ST_DONE;
              tid_valid_q <= 1'b0;
              tid_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              // Look one ID ahead so tid_last is already registered when that ID is presented.
              id_q       <= id_q + (ID_W+1)'(1);
              tid_last_q <= ((id_q + (ID_W+1)'(2)) == cnt_q);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign tid_valid = tid_valid_q;
  assign tid       = id_q[ID_W-1:0];
  assign tid_last  = tid_last_q;
  assign done      = done_q;
endmodule
